// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver states and
// parity mode encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PAR     = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO for received frames. Pointers carry one extra wrap bit
// so full and empty are distinguishable. A write into a full FIFO is
// accepted only if a pop happens in the same cycle; otherwise it is
// dropped and reported on 'drop'.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = rd_en && !empty;
    assign push     = wr_en && (!full || pop);
    assign drop     = wr_en && full && !pop;
    assign rd_valid = !empty;
    // Head is forced to zero while empty so the outputs read 0 after reset
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping; when full, the write slot equals the head slot,
    // so a simultaneous push and pop replaces the entry being popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array holds data only, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity, framing check,
// start-bit glitch rejection and a small show-ahead receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 106,
    parameter int N_BITS     = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              rd_en,
    output logic [N_BITS-1:0] rd_data,
    output logic              rd_perr,
    output logic              rd_ferr,
    output logic              rd_valid,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              glitch,
    output logic              busy
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LD  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LD   = CW'(CLK_DIV - 1);
    localparam int            BW       = 4;
    localparam logic [BW-1:0] LAST_BIT = BW'(N_BITS - 1);
    localparam int            FW       = N_BITS + 2;

    logic              rx_p0;
    logic              rx_p1;
    logic              rx_q;
    rx_state_t         state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [N_BITS-1:0] shreg;
    logic              perr_r;
    logic              tick;
    logic              wr_en;
    logic [FW-1:0]     wr_data;
    logic [FW-1:0]     head;
    logic              drop;

    // Parity check on the assembled data word and the received parity bit
    function automatic logic parity_error(input logic [N_BITS-1:0] d,
                                          input logic p);
        logic x;
        x = (^d) ^ p;
        if (PARITY == PAR_ODD)  return !x;
        if (PARITY == PAR_EVEN) return x;
        return 1'b0;
    endfunction

    assign tick    = (cnt == '0);
    assign busy    = (state != ST_IDLE);
    // The stop sample and the FIFO write happen in the same cycle
    assign wr_en   = (state == ST_STOP) && tick;
    assign wr_data = {~rx_p1, perr_r, shreg};

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_q  <= rx_p1;
        end
    end

    // Receiver FSM; the bit timer is reloaded at every sample so no drift builds up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            perr_r  <= 1'b0;
            glitch  <= 1'b0;
        end else begin
            glitch <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_p1 && rx_q) begin
                        state   <= ST_START;
                        cnt     <= HALF_LD;
                        bit_cnt <= '0;
                        perr_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_p1) begin
                            state  <= ST_IDLE;
                            glitch <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                            cnt   <= BIT_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        cnt     <= BIT_LD;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT)
                            state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PAR: begin
                    if (tick) begin
                        perr_r <= parity_error(shreg, rx_p1);
                        cnt    <= BIT_LD;
                        state  <= ST_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= rx_p1 ? ST_IDLE : ST_WAIT_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    if (rx_p1) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data shift register, LSB received first ends up in bit 0
    always_ff @(posedge clk) begin
        if (state == ST_DATA && tick)
            shreg <= {rx_p1, shreg[N_BITS-1:1]};
    end

    // Sticky overflow; a drop in the same cycle wins over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    uart_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (head),
        .rd_valid(rd_valid),
        .drop    (drop)
    );

    assign rd_data = head[N_BITS-1:0];
    assign rd_perr = head[N_BITS];
    assign rd_ferr = head[N_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table of single frames, directed corner-case
// sequences and random frames checked against a queue-based model.
module tb_uart_rx_fifo;

    localparam int CLK_DIV    = 16;
    localparam int N_BITS     = 8;
    localparam int PARITY     = 2;
    localparam int FIFO_DEPTH = 4;
    // rx passes two synchroniser flops and one edge-detect flop before the FSM reacts
    localparam int SYNC_LAT   = 3;
    // Edge (counted from the start of the stop bit) at which the stop sample is taken
    localparam int STOP_EDGE  = SYNC_LAT + CLK_DIV / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              rd_en;
    logic              ovf_clr;
    logic [N_BITS-1:0] rd_data;
    logic              rd_perr;
    logic              rd_ferr;
    logic              rd_valid;
    logic              overflow;
    logic              glitch;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] d;
        logic       pbit;
        logic       stop;
        int         low_extra;
        logic [7:0] exp_d;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t       tbl [9];
    logic [9:0] model_q [$];

    uart_rx_fifo #(
        .CLK_DIV   (CLK_DIV),
        .N_BITS    (N_BITS),
        .PARITY    (PARITY),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_perr (rd_perr),
        .rd_ferr (rd_ferr),
        .rd_valid(rd_valid),
        .overflow(overflow),
        .ovf_clr (ovf_clr),
        .glitch  (glitch),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic even_pbit(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    // Sends one frame; optionally pops during the stop-sample cycle and
    // checks that rd_valid rises exactly one cycle after that sample.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int low_extra, input bit pop_at_stop, input bit chk_vld);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        rx = stop;
        repeat (STOP_EDGE - 1) @(negedge clk);
        if (chk_vld) chk("vld_before_stop", rd_valid, 1'b0);
        if (pop_at_stop) rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (chk_vld) chk("vld_after_stop", rd_valid, 1'b1);
        repeat (CLK_DIV - STOP_EDGE) @(negedge clk);
        if (!stop) repeat (low_extra) @(negedge clk);
        rx = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_head(input string name, input logic [7:0] d,
                              input logic perr, input logic ferr);
        chk({name, "_valid"}, rd_valid, 1'b1);
        chk({name, "_data"}, rd_data, d);
        chk({name, "_perr"}, rd_perr, perr);
        chk({name, "_ferr"}, rd_ferr, ferr);
    endtask

    initial begin
        int gcount;
        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; ovf_clr = 1'b0;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 0,  8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, 0,  8'h3C, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, 24, 8'h3C, 1'b0, 1'b1};
        tbl[3] = '{8'h00, 1'b0, 1'b1, 0,  8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 0,  8'hFF, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 0,  8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 0,  8'h80, 1'b0, 1'b0};
        tbl[7] = '{8'h01, 1'b0, 1'b1, 0,  8'h01, 1'b1, 1'b0};
        tbl[8] = '{8'h3C, 1'b1, 1'b0, 8,  8'h3C, 1'b1, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_glitch", glitch, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", {rd_ferr, rd_perr, rd_data}, 10'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven single frames, each must leave exactly one entry
        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].d, tbl[i].pbit, tbl[i].stop, tbl[i].low_extra, 1'b0, i == 0);
            check_head($sformatf("tbl%0d", i), tbl[i].exp_d, tbl[i].exp_perr, tbl[i].exp_ferr);
            pop();
            chk($sformatf("tbl%0d_one_entry", i), rd_valid, 1'b0);
        end

        // Short low pulse on idle line: rejected start bit
        rx = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy_mid", busy, 1'b1);
        rx = 1'b1;
        gcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (glitch) gcount++;
        end
        chk("glitch_pulses", gcount, 1);
        chk("glitch_no_write", rd_valid, 1'b0);
        chk("glitch_busy_end", busy, 1'b0);

        // Five frames with no reads: the fifth is dropped
        for (int i = 1; i <= 5; i++) send_frame(8'(i), even_pbit(8'(i)), 1'b1, 0, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check_head($sformatf("ovf_pop%0d", i), 8'(i), 1'b0, 1'b0);
            pop();
        end
        chk("ovf_fifth_absent", rd_valid, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);

        // Full FIFO with a pop in the stop-sample cycle: write accepted
        for (int i = 0; i < 4; i++)
            send_frame(8'h11 + 8'(i), even_pbit(8'h11 + 8'(i)), 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h15, even_pbit(8'h15), 1'b1, 0, 1'b1, 1'b0);
        chk("fullpop_ovf", overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("fullpop%0d", i), 8'h12 + 8'(i), 1'b0, 1'b0);
            pop();
        end
        chk("fullpop_count4", rd_valid, 1'b0);

        // Reset in the middle of the data bits discards the partial frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_write", rd_valid, 1'b0);
        send_frame(8'h5A, even_pbit(8'h5A), 1'b1, 0, 1'b0, 1'b0);
        check_head("midrst_5a", 8'h5A, 1'b0, 1'b0);
        pop();
        chk("midrst_single", rd_valid, 1'b0);

        // Random frames against a queue model of the receive FIFO
        for (int r = 0; r < 6; r++) begin
            int nf;
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                logic [7:0] d;
                logic       pb;
                logic       st;
                logic       perr;
                d    = 8'($urandom);
                pb   = even_pbit(d) ^ ($urandom_range(0, 3) == 0);
                st   = ($urandom_range(0, 3) != 0);
                // Even parity: error when data XOR parity bit is odd
                perr = ((^d) ^ pb);
                model_q.push_back({~st, perr, d});
                send_frame(d, pb, st, int'($urandom_range(0, 20)), 1'b0, 1'b0);
            end
            while (model_q.size() > 0) begin
                logic [9:0] e;
                e = model_q.pop_front();
                chk($sformatf("rand%0d", r), {rd_valid, rd_ferr, rd_perr, rd_data}, {1'b1, e});
                pop();
            end
            chk($sformatf("rand%0d_empty", r), rd_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
